// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead byte FIFO feeding the uart_tx serializer.
// Bytes offered while full are dropped and latched into a sticky overflow flag.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic                     clr_overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_nxt;
    logic [AW:0]      rd_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_ready = !full;
    assign level    = wr_ptr - rd_ptr;

    // flush cancels any push or pop in the same cycle; a flushed push is not a drop
    assign push = in_valid && !full && !flush;
    assign pop  = out_valid && out_ready && !flush;
    assign drop = in_valid && full && !flush;

    // Next pointer values and the entry that will sit at the head after this edge
    always_comb begin
        wr_nxt   = wr_ptr;
        rd_nxt   = rd_ptr;
        head_nxt = '0;
        if (flush) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end else begin
            if (push) wr_nxt = wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_nxt = rd_ptr + {{AW{1'b0}}, 1'b1};
        end
        // the new head may be the byte being written on this very edge
        if (push && (rd_nxt == wr_ptr)) begin
            head_nxt = in_data;
        end else begin
            head_nxt = mem[rd_nxt[AW-1:0]];
        end
    end

    // Storage array write port; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Pointers, registered head stage and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            out_valid <= (wr_nxt != rd_nxt);
            if (wr_nxt != rd_nxt) begin
                out_data <= head_nxt;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed stimulus queues expected bytes,
// an independent monitor pops and compares on every accepted output beat.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic             clr_overflow;
    logic [4:0]       level;
    logic             overflow;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .level        (level),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted output beat must match the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {24'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // Global guard so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte; retries until accepted unless allow_drop is set
    task automatic push_byte(input logic [WIDTH-1:0] b, input bit allow_drop);
        int unsigned tries = 0;
        bit done = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(b);
                done = 1;
            end else if (allow_drop || tries > 100) begin
                if (!allow_drop) check("push_timeout", 32'd1, 32'd0);
                done = 1;
            end
            tries++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 32'd0);
        tick();
        check({name, "_level"}, {27'h0, level}, 32'd0);
        check({name, "_valid"}, {31'h0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        flush        = 1'b0;
        clr_overflow = 1'b0;

        // Reset and single byte
        #12;
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_out_data", {24'h0, out_data}, 32'd0);
        check("rst_level", {27'h0, level}, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
        #11 rst_n = 1'b1;
        tick();
        push_byte(8'h41, 0);
        check("single_valid", {31'h0, out_valid}, 32'd1);
        check("single_data", {24'h0, out_data}, 32'h41);
        check("single_level", {27'h0, level}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_pop_valid", {31'h0, out_valid}, 32'd0);
        check("single_pop_level", {27'h0, level}, 32'd0);
        check("single_sb_empty", exp_q.size(), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 16; i++) push_byte(8'(i), 0);
        check("full_level", {27'h0, level}, 32'd16);
        check("full_in_ready", {31'h0, in_ready}, 32'd0);
        check("full_ovf_before", {31'h0, overflow}, 32'd0);
        push_byte(8'hAA, 1);
        check("full_ovf_after", {31'h0, overflow}, 32'd1);
        check("full_level_hold", {27'h0, level}, 32'd16);
        out_ready = 1'b1;
        wait_drain("fill_drain");
        out_ready = 1'b0;

        // Flush with a concurrent push; overflow is still 1 here
        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i), 0);
        check("pre_flush_level", {27'h0, level}, 32'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        exp_q.delete();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_level", {27'h0, level}, 32'd0);
        check("flush_valid", {31'h0, out_valid}, 32'd0);
        check("flush_in_ready", {31'h0, in_ready}, 32'd1);
        check("flush_ovf_kept", {31'h0, overflow}, 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;

        // Overflow ordering: set beats clear
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 0);
        clr_overflow = 1'b1;
        push_byte(8'hEE, 1);
        clr_overflow = 1'b0;
        check("ovf_set_wins", {31'h0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_cleared", {31'h0, overflow}, 32'd0);
        out_ready = 1'b1;
        wait_drain("ovf_drain");

        // Concurrent push/pop across several pointer wraps
        for (int i = 0; i < 40; i++) push_byte(8'(i), 0);
        wait_drain("wrap_drain");
        check("wrap_ovf", {31'h0, overflow}, 32'd0);
        out_ready = 1'b0;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) push_byte(8'hC0 + 8'(i), 0);
        check("pre_rst_level", {27'h0, level}, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_level", {27'h0, level}, 32'd0);
        check("arst_valid", {31'h0, out_valid}, 32'd0);
        check("arst_data", {24'h0, out_data}, 32'd0);
        check("arst_in_ready", {31'h0, in_ready}, 32'd1);
        #1 rst_n = 1'b1;
        tick();
        push_byte(8'h30, 0);
        check("post_rst_data", {24'h0, out_data}, 32'h30);
        out_ready = 1'b1;
        wait_drain("post_rst_drain");
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
